// File: rtl/ycr_tcm_sp_arb.sv
// ycr_tcm_sp_arb: shares one 1RW SRAM macro between the core imem (read-only) and dmem TCM ports.
// Define YCR_TCM_ARB_RR_EN for round-robin arbitration; default is fixed priority, DMEM over IMEM.
`ifndef YCR_IMEM_AWIDTH
`define YCR_IMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif

module ycr_tcm_sp_arb #(
  parameter int SRAM_AW = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        imem_req,
  input  logic [`YCR_IMEM_AWIDTH-1:0] imem_addr,
  output logic                        imem_req_ack,
  output logic [31:0]                 imem_rdata,
  output logic [1:0]                  imem_resp,

  input  logic                        dmem_req,
  input  logic                        dmem_cmd,
  input  logic [1:0]                  dmem_width,
  input  logic [`YCR_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [31:0]                 dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [31:0]                 dmem_rdata,
  output logic [1:0]                  dmem_resp,

  output logic                        sram_clk,
  output logic                        sram_csb,
  output logic                        sram_web,
  output logic [SRAM_AW-1:0]          sram_addr,
  output logic [3:0]                  sram_wmask,
  output logic [31:0]                 sram_din,
  input  logic [31:0]                 sram_dout
);

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_RDY_OK = 2'b01;
  localparam logic [1:0] RESP_RDY_ER = 2'b10;

  localparam logic       CMD_WR  = 1'b1;
  localparam logic [1:0] W_BYTE  = 2'd0;
  localparam logic [1:0] W_HWORD = 2'd1;
  localparam logic [1:0] W_WORD  = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMEM = 2'd1,
    GNT_DMEM = 2'd2
  } gnt_e;

  gnt_e       gnt;
  gnt_e       gnt_nxt;
  logic       imem_pend;
  logic       dmem_pend;
  logic       dmem_misaligned;
  logic       dmem_rd_q;
  logic [1:0] addr_lsb_q;

  logic       unused_addr_bits;
  assign unused_addr_bits = ^{imem_addr[`YCR_IMEM_AWIDTH-1:SRAM_AW+2], imem_addr[1:0],
                              dmem_addr[`YCR_DMEM_AWIDTH-1:SRAM_AW+2]};

  assign sram_clk     = clk;
  assign imem_req_ack = (gnt == GNT_IMEM);
  assign dmem_req_ack = (gnt == GNT_DMEM);

  // A port being acked this cycle still holds req; masking it keeps a port from
  // being granted back-to-back, which guarantees the other port a slot.
  assign imem_pend = imem_req & ~imem_req_ack;
  assign dmem_pend = dmem_req & ~dmem_req_ack;

  // The reserved width encoding is rejected together with the misaligned cases.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    dmem_misaligned = 1'b0;
    unique case (dmem_width)
      W_BYTE:  dmem_misaligned = 1'b0;
      W_HWORD: dmem_misaligned = dmem_addr[0];
      W_WORD:  dmem_misaligned = (dmem_addr[1:0] != 2'b00);
      default: dmem_misaligned = 1'b1;
    endcase
  end

`ifdef YCR_TCM_ARB_RR_EN
  logic rr_last_dmem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_dmem <= 1'b0;
    end else if (gnt_nxt != GNT_NONE) begin
      rr_last_dmem <= (gnt_nxt == GNT_DMEM);
    end
  end
`endif

  always_comb begin
    gnt_nxt = GNT_NONE;
    if (dmem_pend && imem_pend) begin
`ifdef YCR_TCM_ARB_RR_EN
      gnt_nxt = rr_last_dmem ? GNT_IMEM : GNT_DMEM;
`else
      gnt_nxt = GNT_DMEM;
`endif
    end else if (dmem_pend) begin
      gnt_nxt = GNT_DMEM;
    end else if (imem_pend) begin
      gnt_nxt = GNT_IMEM;
    end
  end

  // SRAM is driven during the grant cycle straight from the granted port, whose
  // request fields are still held stable by the handshake.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = '0;
    sram_wmask = 4'h0;
    sram_din   = 32'h0;
    case (gnt)
      GNT_IMEM: begin
        sram_csb  = 1'b0;
        sram_addr = imem_addr[SRAM_AW+1:2];
      end
      GNT_DMEM: begin
        if (!dmem_misaligned) begin
          sram_csb  = 1'b0;
          sram_addr = dmem_addr[SRAM_AW+1:2];
          if (dmem_cmd == CMD_WR) begin
            sram_web = 1'b0;
            case (dmem_width)
              W_BYTE: begin
                sram_din   = {4{dmem_wdata[7:0]}};
                sram_wmask = 4'b0001 << dmem_addr[1:0];
              end
              W_HWORD: begin
                sram_din   = {2{dmem_wdata[15:0]}};
                sram_wmask = 4'b0011 << {dmem_addr[1], 1'b0};
              end
              default: begin
                sram_din   = dmem_wdata;
                sram_wmask = 4'hF;
              end
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= GNT_NONE;
      imem_resp  <= RESP_NOTRDY;
      dmem_resp  <= RESP_NOTRDY;
      dmem_rd_q  <= 1'b0;
      addr_lsb_q <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      gnt        <= gnt_nxt;
      imem_resp  <= (gnt == GNT_IMEM) ? RESP_RDY_OK : RESP_NOTRDY;
      dmem_resp  <= (gnt != GNT_DMEM) ? RESP_NOTRDY :
                    (dmem_misaligned  ? RESP_RDY_ER : RESP_RDY_OK);
      dmem_rd_q  <= (gnt == GNT_DMEM) && (dmem_cmd != CMD_WR) && !dmem_misaligned;
      if (gnt == GNT_DMEM) begin
        addr_lsb_q <= dmem_addr[1:0];
      end
    end
  end

  // Read data comes straight from the macro in the response cycle; zero otherwise.
  assign imem_rdata = (imem_resp == RESP_RDY_OK) ? sram_dout : 32'h0;
  assign dmem_rdata = dmem_rd_q ? (sram_dout >> {addr_lsb_q, 3'b000}) : 32'h0;

`ifndef SYNTHESIS
  a_imem_ack_resp_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_req_ack && (imem_resp != RESP_NOTRDY)));
  a_dmem_ack_resp_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(dmem_req_ack && (dmem_resp != RESP_NOTRDY)));
`endif

endmodule

// File: tb/tb_ycr_tcm_sp_arb.sv
// Directed bench for ycr_tcm_sp_arb with a behavioural 1RW SRAM model and hand-computed expectations.
`timescale 1ns/1ps

module tb_ycr_tcm_sp_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_resp;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic        sram_clk;
  logic        sram_csb;
  logic        sram_web;
  logic [8:0]  sram_addr;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ycr_tcm_sp_arb #(.SRAM_AW(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_req_ack (imem_req_ack),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .sram_clk     (sram_clk),
    .sram_csb     (sram_csb),
    .sram_web     (sram_web),
    .sram_addr    (sram_addr),
    .sram_wmask   (sram_wmask),
    .sram_din     (sram_din),
    .sram_dout    (sram_dout)
  );

  // 1RW SRAM model: masked write, or registered read, whenever csb is low.
  always @(posedge sram_clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic dmem_start(input logic cmd, input logic [1:0] width,
                            input logic [31:0] addr, input logic [31:0] wdata);
    dmem_cmd   = cmd;
    dmem_width = width;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    dmem_req   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_acks, i_acks, d_resps, i_resps;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[2] = 32'h1234_5678;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h5555_5555;
    sram_dout  = 32'h0;
    rst_n      = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = 32'h0;
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_width = 2'd0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;

    // Reset state
    step();
    step();
    check("rst_imem_ack",   {31'h0, imem_req_ack}, 32'h0);
    check("rst_dmem_ack",   {31'h0, dmem_req_ack}, 32'h0);
    check("rst_imem_resp",  {30'h0, imem_resp},    32'h0);
    check("rst_dmem_resp",  {30'h0, dmem_resp},    32'h0);
    check("rst_csb",        {31'h0, sram_csb},     32'h1);
    check("rst_web",        {31'h0, sram_web},     32'h1);
    check("rst_addr",       {23'h0, sram_addr},    32'h0);
    check("rst_wmask",      {28'h0, sram_wmask},   32'h0);
    check("rst_din",        sram_din,              32'h0);
    check("rst_imem_rdata", imem_rdata,            32'h0);
    check("rst_dmem_rdata", dmem_rdata,            32'h0);
    rst_n = 1'b1;
    step();

    // Lone imem read of word 4
    imem_addr = 32'h0000_0010;
    imem_req  = 1'b1;
    check("imem_T_noack", {31'h0, imem_req_ack}, 32'h0);
    step();
    check("imem_G_ack",  {31'h0, imem_req_ack}, 32'h1);
    check("imem_G_csb",  {31'h0, sram_csb},     32'h0);
    check("imem_G_web",  {31'h0, sram_web},     32'h1);
    check("imem_G_addr", {23'h0, sram_addr},    32'h4);
    imem_req = 1'b0;
    step();
    check("imem_R_resp",  {30'h0, imem_resp},    32'h1);
    check("imem_R_rdata", imem_rdata,            32'hDEAD_BEEF);
    check("imem_R_noack", {31'h0, imem_req_ack}, 32'h0);
    step();
    check("imem_resp_pulse", {30'h0, imem_resp}, 32'h0);

    // dmem BYTE write 0xA5 at 0x6
    dmem_start(1'b1, 2'd0, 32'h0000_0006, 32'h0000_00A5);
    step();
    check("bw_G_ack",   {31'h0, dmem_req_ack}, 32'h1);
    check("bw_G_csb",   {31'h0, sram_csb},     32'h0);
    check("bw_G_web",   {31'h0, sram_web},     32'h0);
    check("bw_G_addr",  {23'h0, sram_addr},    32'h1);
    check("bw_G_wmask", {28'h0, sram_wmask},   32'h4);
    check("bw_G_din",   sram_din,              32'hA5A5_A5A5);
    dmem_req = 1'b0;
    step();
    check("bw_R_resp",  {30'h0, dmem_resp}, 32'h1);
    check("bw_R_rdata", dmem_rdata,         32'h0);
    check("bw_idle_csb", {31'h0, sram_csb}, 32'h1);

    // WORD read of 0x4 sees the written byte
    dmem_start(1'b0, 2'd2, 32'h0000_0004, 32'h0);
    step();
    check("wr_G_web",   {31'h0, sram_web},   32'h1);
    check("wr_G_wmask", {28'h0, sram_wmask}, 32'h0);
    check("wr_G_din",   sram_din,            32'h0);
    dmem_req = 1'b0;
    step();
    check("wr_R_resp",  {30'h0, dmem_resp}, 32'h1);
    check("wr_R_rdata", dmem_rdata,         32'h00A5_0000);

    // HWORD write 0xBEEF at 0xA, then BYTE read at 0xB
    dmem_start(1'b1, 2'd1, 32'h0000_000A, 32'h0000_BEEF);
    step();
    check("hw_G_wmask", {28'h0, sram_wmask}, 32'hC);
    check("hw_G_din",   sram_din,            32'hBEEF_BEEF);
    check("hw_G_addr",  {23'h0, sram_addr},  32'h2);
    dmem_req = 1'b0;
    step();
    dmem_start(1'b0, 2'd0, 32'h0000_000B, 32'h0);
    step();
    dmem_req = 1'b0;
    step();
    check("br_R_rdata", dmem_rdata, 32'h0000_00BE);
    check("hw_mem2",    mem[2],     32'hBEEF_5678);

    // Misaligned HWORD read at 0x3
    dmem_start(1'b0, 2'd1, 32'h0000_0003, 32'h0);
    step();
    check("mis_G_ack", {31'h0, dmem_req_ack}, 32'h1);
    check("mis_G_csb", {31'h0, sram_csb},     32'h1);
    dmem_req = 1'b0;
    step();
    check("mis_R_resp",  {30'h0, dmem_resp}, 32'h2);
    check("mis_R_rdata", dmem_rdata,         32'h0);

    // Misaligned WORD write at 0x5 leaves memory untouched
    dmem_start(1'b1, 2'd2, 32'h0000_0005, 32'hFFFF_FFFF);
    step();
    check("misw_G_csb", {31'h0, sram_csb}, 32'h1);
    dmem_req = 1'b0;
    step();
    check("misw_R_resp", {30'h0, dmem_resp}, 32'h2);
    check("misw_mem1",   mem[1],             32'h00A5_0000);

    // Continuous contention for 20 cycles
    imem_addr = 32'h0000_0010;
    imem_req  = 1'b1;
    dmem_start(1'b0, 2'd2, 32'h0000_0004, 32'h0);
    d_acks = 0; i_acks = 0; d_resps = 0; i_resps = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k <= 20) begin
        check($sformatf("cont_ack_%0d", k), {30'h0, dmem_req_ack, imem_req_ack},
              (k % 2 == 1) ? 32'h2 : 32'h1);
        check($sformatf("cont_csb_%0d", k), {31'h0, sram_csb}, 32'h0);
      end
      if (dmem_req_ack) d_acks++;
      if (imem_req_ack) i_acks++;
      if (dmem_resp == 2'b01) begin
        d_resps++;
        check($sformatf("cont_drd_%0d", k), dmem_rdata, 32'h00A5_0000);
      end
      if (imem_resp == 2'b01) begin
        i_resps++;
        check($sformatf("cont_ird_%0d", k), imem_rdata, 32'hDEAD_BEEF);
      end
      if (k == 20) begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
      end
    end
    check("cont_d_acks",  d_acks,  32'd10);
    check("cont_i_acks",  i_acks,  32'd10);
    check("cont_d_resps", d_resps, 32'd10);
    check("cont_i_resps", i_resps, 32'd10);

    // Simultaneous first request after reset, then a second contended grant
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    imem_req = 1'b1;
    dmem_start(1'b0, 2'd2, 32'h0000_0004, 32'h0);
    step();
    check("first_gnt", {30'h0, dmem_req_ack, imem_req_ack}, 32'h2);
    imem_req = 1'b0;
    dmem_req = 1'b0;
    step();
    imem_req = 1'b1;
    dmem_req = 1'b1;
    step();
`ifdef YCR_TCM_ARB_RR_EN
    check("second_gnt", {30'h0, dmem_req_ack, imem_req_ack}, 32'h1);
`else
    check("second_gnt", {30'h0, dmem_req_ack, imem_req_ack}, 32'h2);
`endif
    imem_req = 1'b0;
    dmem_req = 1'b0;
    step();
    step();

    // Reset pulse during the grant cycle of a write
    dmem_start(1'b1, 2'd2, 32'h0000_0020, 32'hCAFE_F00D);
    step();
    check("rw_G_ack", {31'h0, dmem_req_ack}, 32'h1);
    check("rw_G_csb", {31'h0, sram_csb},     32'h0);
    rst_n = 1'b0;
    #1;
    check("rw_rst_csb", {31'h0, sram_csb},     32'h1);
    check("rw_rst_web", {31'h0, sram_web},     32'h1);
    check("rw_rst_ack", {31'h0, dmem_req_ack}, 32'h0);
    dmem_req = 1'b0;
    step();
    check("rw_rst_resp", {30'h0, dmem_resp}, 32'h0);
    rst_n = 1'b1;
    step();
    check("rw_post_resp", {30'h0, dmem_resp}, 32'h0);
    check("rw_mem8",      mem[8],             32'h5555_5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ycr_tcm_sp_arb.md
# ycr_tcm_sp_arb

Single-port TCM arbiter: shares one 1RW SRAM macro (32-bit, 1-cycle read latency) between the core instruction port (read-only) and the core data port (read/write). Uses the core memory handshake: `req` held until a one-cycle `req_ack`, then a one-cycle `resp` with data. Sits between the core imem/dmem TCM interfaces and the SRAM macro, replacing the dual-port SRAM arrangement where area requires a single-port macro.

## Interface
- `SRAM_AW`, 9: SRAM word-address width; SRAM is indexed by `addr[SRAM_AW+1:2]`.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` in 1: instruction read request, held until `imem_req_ack`.
- `imem_addr` in `YCR_IMEM_AWIDTH`: byte address, word-aligned.
- `imem_req_ack` out 1: one-cycle grant pulse.
- `imem_rdata` out 32: instruction word, valid while `imem_resp`=RDY_OK.
- `imem_resp` out 2: NOTRDY/RDY_OK/RDY_ER.
- `dmem_req` in 1: data request, held until `dmem_req_ack`.
- `dmem_cmd` in 1: RD=0, WR=1.
- `dmem_width` in 2: BYTE=0, HWORD=1, WORD=2.
- `dmem_addr` in `YCR_DMEM_AWIDTH`: byte address.
- `dmem_wdata` in 32: write data, right-justified.
- `dmem_req_ack` out 1: one-cycle grant pulse.
- `dmem_rdata` out 32: read data shifted right by `8*addr[1:0]`, valid while `dmem_resp`=RDY_OK on reads.
- `dmem_resp` out 2: NOTRDY/RDY_OK/RDY_ER.
- `sram_clk` out 1: equals `clk`.
- `sram_csb` out 1: chip select, active low.
- `sram_web` out 1: write enable, active low.
- `sram_addr` out `SRAM_AW`: word address.
- `sram_wmask` out 4: byte write mask.
- `sram_din` out 32: write data.
- `sram_dout` in 32: read data, valid the cycle after `csb`=0.

## Operation
- Grant register `gnt` holds IMEM, DMEM or NONE. It is updated every edge from `{imem_req, dmem_req}`, masking the requester acked in the current cycle, whose `req` is still high.
- Grant cycle (G): `*_req_ack`=1 for the granted port. SRAM is driven from the granted port's inputs: `csb`=0; `web`=~(dmem & WR); `addr`=`addr[SRAM_AW+1:2]`.
- Write formatting: BYTE replicates `wdata[7:0]` x4 with `wmask=4'b0001<<addr[1:0]`. HWORD replicates `wdata[15:0]` x2 with `wmask=4'b0011<<{addr[1],0}`. WORD uses `wmask=4'hF`. On reads, `wmask`=0 and `din`=0.
- Response cycle (G+1): the granted port gets `resp`=RDY_OK. `imem_rdata`=`sram_dout`. `dmem_rdata`=`sram_dout>>(8*addr_lsb_q)`, where `addr_lsb_q` is registered in G.
- Misaligned dmem access (HWORD with `addr[0]`=1, or WORD with `addr[1:0]`≠0) is still acked in G, but `csb` stays 1 (no SRAM access) and G+1 returns RDY_ER.
- Arbitration when both requests are pending: DMEM wins (fixed priority). With RR enabled, see Configuration.
- The arbiter can grant every cycle, alternating ports. A single port is granted at most every second cycle, so the other port cannot be starved.
- Idle (no grant): `csb`=1, `web`=1, both `req_ack`=0.

## Timing
- Reset values, applied asynchronously: `gnt`=NONE; `imem_req_ack`=`dmem_req_ack`=0; both `resp`=NOTRDY (2'b00); `sram_csb`=`sram_web`=1; `sram_addr`/`wmask`/`din`=0; `*_rdata`=0; RR pointer=IMEM.
- Latency: `req` rises in cycle T → `req_ack` in T+1 (uncontended) → `resp` in T+2.
- `resp` and `req_ack` are each one-cycle pulses, never asserted on the same port in the same cycle.
- If reset asserts mid-access, all outputs return to reset values immediately. The in-flight response is dropped and no SRAM write occurs after reset assertion.
- A `req` that is dropped before ack is simply not granted (it is not a protocol error).

## Configuration
- `YCR_TCM_ARB_RR_EN` defined: round-robin arbitration. On contention, grant goes to the port not granted last; the pointer updates on every grant.
- Without the macro: fixed priority, DMEM over IMEM; the RR pointer flop is removed.

## Test plan
- Lone imem read at addr 0x0000_0010, SRAM word 4 = 0xDEADBEEF → `csb`=0 and `addr`=4 in T+1, `imem_resp`=RDY_OK and `imem_rdata`=0xDEADBEEF in T+2.
- dmem BYTE write 0xA5 at 0x0000_0006 → `web`=0, `wmask`=4'b0100, `din`=0xA5A5A5A5. A following WORD read of 0x4 → `dmem_rdata`=0x00A5xxxx pattern consistent with the model.
- Both requests asserted continuously for 20 cycles → grants alternate D,I,D,I…. Each port gets 10 acks and 10 RDY_OK; `csb`=0 every cycle after the first.
- Simultaneous first request after reset: without the macro, DMEM is first; with `YCR_TCM_ARB_RR_EN`, DMEM is first, then IMEM wins the next contended grant.
- dmem HWORD read at 0x0000_0003 → acked, `csb` stays 1, `dmem_resp`=RDY_ER next cycle.
- `rst_n` pulsed low in the grant cycle of a write → `csb`/`web` go to 1 immediately, no `resp` is issued, and the SRAM contents are unchanged.
